// File: rtl/cache_types.sv
// Shared types for the cache-to-memory arbiter: FSM states, port ids, line width.
package cache_types;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/arb_line_reg.sv
// Line-wide register with load enable and async clear; holds a cache line
// between loads so the consumer always sees a stable value.
module arb_line_reg #(
    parameter int LINE_W = cache_types::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] din,
    output logic [LINE_W-1:0] dout
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // Next value: new line on load, otherwise hold
    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = din;
        end
    end

    // Line storage, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign dout = line_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single memory port.
// One transaction at a time: IDLE picks a winner, GRANT_x holds the memory
// strobe until mem_resp, RESP pulses the client resp for one cycle.
module cache_arbiter
    import cache_types::*;
#(
    parameter int LINE_W     = cache_types::LINE_W,
    parameter int ADDR_W     = 32,
    parameter bit D_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q,       state_d;
    arb_port_t         last_grant_q,  last_grant_d;
    logic              mem_read_q,    mem_read_d;
    logic              mem_write_q,   mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              i_resp_q,      i_resp_d;
    logic              d_resp_q,      d_resp_d;
    logic              wdata_load;
    logic              i_rdata_load;
    logic              d_rdata_load;
    logic              d_req;
    logic              pick_d;

    assign d_req = d_pmem_read | d_pmem_write;
    // D wins when it is alone, when it has fixed priority, or when I was served last
    assign pick_d = d_req & (~i_pmem_read | D_PRIORITY | (last_grant_q == PORT_I));

    // Next-state, grant selection and transaction latching
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        i_resp_d      = 1'b0;
        d_resp_d      = 1'b0;
        wdata_load    = 1'b0;
        i_rdata_load  = 1'b0;
        d_rdata_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    // Write wins if the D-cache illegally raises both
                    state_d       = GRANT_D;
                    mem_write_d   = d_pmem_write;
                    mem_read_d    = ~d_pmem_write;
                    mem_address_d = d_pmem_address;
                    wdata_load    = 1'b1;
                end else if (i_pmem_read) begin
                    state_d       = GRANT_I;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    mem_address_d = i_pmem_address;
                end
            end
            GRANT_I: begin
                if (mem_resp) begin
                    state_d      = RESP;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    i_rdata_load = 1'b1;
                    i_resp_d     = 1'b1;
                    last_grant_d = PORT_I;
                end
            end
            GRANT_D: begin
                if (mem_resp) begin
                    state_d      = RESP;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    // A writeback leaves the D-cache read line untouched
                    d_rdata_load = mem_read_q;
                    d_resp_d     = 1'b1;
                    last_grant_d = PORT_D;
                end
            end
            // The served cache still shows its request here, so requests are ignored
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered control outputs; reset drops the strobes immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT_I;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            i_resp_q      <= 1'b0;
            d_resp_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            i_resp_q      <= i_resp_d;
            d_resp_q      <= d_resp_d;
        end
    end

    arb_line_reg #(.LINE_W(LINE_W)) u_wdata_reg (
        .clk  (clk),
        .rst  (rst),
        .load (wdata_load),
        .din  (d_pmem_wdata),
        .dout (mem_wdata)
    );

    arb_line_reg #(.LINE_W(LINE_W)) u_i_rdata_reg (
        .clk  (clk),
        .rst  (rst),
        .load (i_rdata_load),
        .din  (mem_rdata),
        .dout (i_pmem_rdata)
    );

    arb_line_reg #(.LINE_W(LINE_W)) u_d_rdata_reg (
        .clk  (clk),
        .rst  (rst),
        .load (d_rdata_load),
        .din  (mem_rdata),
        .dout (d_pmem_rdata)
    );

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign i_pmem_resp = i_resp_q;
    assign d_pmem_resp = d_resp_q;

    rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

endmodule
